// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers; MULT/DIV occupy the unit for a fixed cycle count, MTHI/MTLO take one edge.
// Latency MULT_CYCLES or DIV_CYCLES edges from accept to HI/LO write; start is ignored while busy, stall flags the conflict.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   b_safe, quo, rem, res_hi, res_lo;
    logic               div_zero, div_ovf;

    // Result is computed from the latched operands and only committed on the final busy edge.
    always_comb begin
        div_zero = (b_q == '0);
        div_ovf  = (op_q == OP_DIV) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        // Substitute a harmless divisor so the special cases never reach the divider.
        b_safe   = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
        if (op_q == OP_MULT) begin
            prod = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        end else begin
            prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        end
        if (op_q == OP_DIV) begin
            quo = $signed(a_q) / $signed(b_safe);
            rem = $signed(a_q) % $signed(b_safe);
        end else begin
            quo = a_q / b_safe;
            rem = a_q % b_safe;
        end
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_q == OP_DIV || op_q == OP_DIVU) begin
            if (div_zero) begin
                res_hi = a_q;
                res_lo = '1;
            end else if (div_ovf) begin
                res_hi = '0;
                res_lo = a_q;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU: begin
                            state_d = RUN;
                            cnt_d   = MULT_N;
                            op_d    = mdu_op;
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = RUN;
                            cnt_d   = DIV_N;
                            op_d    = mdu_op;
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign stall = busy | (start & (mdu_op >= OP_MULT) & (mdu_op <= OP_DIVU));
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] A, B;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_hi, exp_lo;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Architectural result of a long op as {hi, lo}.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        int              sa, sb;
        logic [31:0]     q, r;
        case (op)
            3'd1: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                return ps;
            end
            3'd2: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                return pu;
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                sa = a;
                sb = b;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] res;
        int n;
        n = (op <= 3'd2) ? 5 : 10;
        res = model(op, a, b);
        start = 1'b1; mdu_op = op; A = a; B = b;
        #1 chk("stall_on_request", stall, 1);
        tick();
        for (int k = 0; k < n; k++) begin
            chk("busy_during_op", busy, 1);
            chk("done_low_during_op", done, 0);
            chk("hilo_held_during_op", {hi, lo}, {exp_hi, exp_lo});
            // Requests issued while busy, including an MTHI, must be dropped.
            if (k == 0) begin
                start = 1'b1; mdu_op = 3'd5; A = 32'hA5; B = $urandom;
            end else begin
                start = 1'($urandom); mdu_op = 3'($urandom); A = $urandom; B = $urandom;
            end
            tick();
        end
        start = 1'b0; mdu_op = 3'd0;
        {exp_hi, exp_lo} = res;
        chk("busy_clear_at_end", busy, 0);
        chk("done_pulse", done, 1);
        chk("hilo_result", {hi, lo}, {exp_hi, exp_lo});
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
        start = 1'b1; mdu_op = op; A = a; B = $urandom;
        #1 chk("stall_low_for_mt", stall, 0);
        tick();
        start = 1'b0;
        if (op == 3'd5) exp_hi = a;
        else exp_lo = a;
        chk("hilo_after_mt", {hi, lo}, {exp_hi, exp_lo});
        chk("busy_after_mt", busy, 0);
        chk("done_after_mt", done, 0);
    endtask

    initial begin
        int pulses;
        logic [2:0] rop;
        reset = 1'b1; start = 1'b0; mdu_op = 3'd0; A = '0; B = '0;
        tick();
        start = 1'b1; mdu_op = 3'd1; A = 32'd3; B = 32'd4;
        #1 chk("stall_in_reset", stall, 1);
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0; start = 1'b0;
        exp_hi = '0; exp_lo = '0;
        tick();
        chk("idle_busy", busy, 0);

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd4, 32'd7, 32'd2);
        run_op(3'd4, 32'h1234, 32'd0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'hFFFF_FFFE);
        mt_op(3'd6, 32'h5A);
        mt_op(3'd5, 32'hCAFE_F00D);

        for (int i = 0; i < 2; i++) begin
            start = 1'b1; mdu_op = (i == 0) ? 3'd0 : 3'd7; A = $urandom; B = $urandom;
            #1 chk("stall_low_for_nop", stall, 0);
            tick();
            start = 1'b0;
            chk("nop_hilo", {hi, lo}, {exp_hi, exp_lo});
            chk("nop_busy", busy, 0);
        end

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(1, 6));
            if (rop >= 3'd5) mt_op(rop, $urandom);
            else run_op(rop, rnd_opnd(), rnd_opnd());
        end

        // Abort a divide three cycles in.
        start = 1'b1; mdu_op = 3'd3; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("busy_before_abort", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_busy", busy, 0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done || busy) pulses++;
        end
        chk("no_done_after_abort", pulses, 0);
        chk("hilo_after_abort", {hi, lo}, {exp_hi, exp_lo});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
